// File: rtl/kfmmc_data_line.sv
// Byte-wide MMC DAT line engine: shifts one byte out or in on DAT, generating the card clock.
// Define KFMMC_DATA_CRC_EN to build the running CRC16-CCITT on data_crc.
module kfmmc_data_line #(
  parameter int CLOCK_DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_communication,
  input  logic        data_io,
  input  logic        check_data_start_bit,
  input  logic        clear_data_crc,
  input  logic        clear_data_interrupt,
  input  logic        mask_data_interrupt,
  input  logic        set_send_data,
  input  logic [7:0]  send_data,
  output logic [7:0]  received_data,
  output logic        mmc_is_in_connecting,
  output logic        sent_data_interrupt,
  output logic        received_data_interrupt,
  output logic        mmc_clock,
  input  logic        mmc_dat_in,
  output logic        mmc_dat_out,
  output logic        mmc_dat_oe,
  output logic [15:0] data_crc
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_START, S_SHIFT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_div;
  logic        r_mmc_clock;
  logic        r_dat_out;
  logic        r_dat_oe;
  logic        r_dir_rx;
  logic [7:0]  r_shift;
  logic [7:0]  r_received;
  logic [2:0]  r_bit_count;
  logic        r_sent_flag;
  logic        r_recv_flag;

  logic w_accept;
  logic w_running;
  logic w_wrap;
  logic w_fall_tick;
  logic w_rise_tick;
  logic w_tx_tick;
  logic w_rx_tick;
  logic w_tx_finish;
  logic w_rx_last;
  logic w_start_seen;

  assign w_accept     = (r_state == S_IDLE) && start_communication;
  assign w_running    = (r_state == S_WAIT_START) || (r_state == S_SHIFT);
  assign w_wrap       = w_running && (r_div == 8'(CLOCK_DIV - 1));
  assign w_fall_tick  = w_wrap && r_mmc_clock;
  assign w_rise_tick  = w_wrap && !r_mmc_clock;
  assign w_tx_tick    = (r_state == S_SHIFT) && !r_dir_rx && w_fall_tick;
  assign w_rx_tick    = (r_state == S_SHIFT) && r_dir_rx && w_rise_tick;
  assign w_tx_finish  = w_tx_tick && r_dat_oe && (r_bit_count == 3'd7);
  assign w_rx_last    = w_rx_tick && (r_bit_count == 3'd7);
  assign w_start_seen = (r_state == S_WAIT_START) && w_rise_tick && !mmc_dat_in;

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:       if (start_communication)
                      w_state_next = (data_io && check_data_start_bit) ? S_WAIT_START : S_SHIFT;
      S_WAIT_START: if (w_start_seen) w_state_next = S_SHIFT;
      S_SHIFT:      if (w_tx_finish || w_rx_last) w_state_next = S_DONE;
      S_DONE:       w_state_next = S_IDLE;
      default:      w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mmc_is_in_connecting    = (r_state != S_IDLE);
    sent_data_interrupt     = r_sent_flag && !mask_data_interrupt;
    received_data_interrupt = r_recv_flag && !mask_data_interrupt;
  end

  // The finishing falling tick leaves mmc_clock high so the card sees no stray edge.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      r_div       <= 8'd0;
      r_mmc_clock <= 1'b1;
    end else if (!w_running) begin
      r_div       <= 8'd0;
      r_mmc_clock <= 1'b1;
    end else if (w_wrap) begin
      r_div <= 8'd0;
      if (!w_tx_finish) r_mmc_clock <= ~r_mmc_clock;
    end else begin
      r_div <= r_div + 8'd1;
    end
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      r_shift     <= 8'h00;
      r_bit_count <= 3'd0;
      r_dat_out   <= 1'b1;
      r_dat_oe    <= 1'b0;
      r_received  <= 8'h00;
      r_dir_rx    <= 1'b0;
    end else if (w_accept) begin
      r_dir_rx    <= data_io;
      r_bit_count <= 3'd0;
      if (set_send_data) r_shift <= send_data;
    end else if (w_tx_tick) begin
      // First falling tick only raises OE with the MSB; later ticks advance the count.
      if (!r_dat_oe) begin
        r_dat_oe  <= 1'b1;
        r_dat_out <= r_shift[7];
        r_shift   <= {r_shift[6:0], 1'b0};
      end else if (r_bit_count == 3'd7) begin
        r_dat_oe  <= 1'b0;
        r_dat_out <= 1'b1;
      end else begin
        r_dat_out   <= r_shift[7];
        r_shift     <= {r_shift[6:0], 1'b0};
        r_bit_count <= r_bit_count + 3'd1;
      end
    end else if (w_rx_tick) begin
      r_shift     <= {r_shift[6:0], mmc_dat_in};
      r_bit_count <= r_bit_count + 3'd1;
      if (r_bit_count == 3'd7) r_received <= {r_shift[6:0], mmc_dat_in};
    end
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      r_sent_flag <= 1'b0;
      r_recv_flag <= 1'b0;
    end else begin
      if (w_tx_finish)               r_sent_flag <= 1'b1;
      else if (clear_data_interrupt) r_sent_flag <= 1'b0;
      if (w_rx_last)                 r_recv_flag <= 1'b1;
      else if (clear_data_interrupt) r_recv_flag <= 1'b0;
    end
  end

  assign received_data = r_received;
  assign mmc_clock     = r_mmc_clock;
  assign mmc_dat_out   = r_dat_out;
  assign mmc_dat_oe    = r_dat_oe;

`ifdef KFMMC_DATA_CRC_EN
  logic [15:0] r_crc;
  logic        w_crc_valid;
  logic        w_crc_bit;

  assign w_crc_valid = (w_tx_tick && !w_tx_finish) || w_rx_tick;
  assign w_crc_bit   = r_dir_rx ? mmc_dat_in : r_shift[7];

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      r_crc <= 16'h0000;
    end else if (w_accept) begin
      if (clear_data_crc) r_crc <= 16'h0000;
    end else if (w_crc_valid) begin
      r_crc <= {r_crc[14:0], 1'b0} ^ ((r_crc[15] ^ w_crc_bit) ? 16'h1021 : 16'h0000);
    end
  end

  assign data_crc = r_crc;
`else
  logic w_unused_clear_crc;
  assign w_unused_clear_crc = clear_data_crc;
  assign data_crc = 16'h0000;
`endif

endmodule
